// File: rtl/producer_mc.sv
// producer_mc: multi-channel write-side producer feeding one FIFO write port.
// Per-channel circular buffers drained round-robin, all in the write-clock domain.
module producer_mc #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    parameter  int CH_DEPTH   = 4,
    localparam int CW         = $clog2(NUM_CH)
) (
    input  logic                         w_clk,
    input  logic                         wrst,
    input  logic [NUM_CH-1:0]            wr_req,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]            ch_full,
    output logic [NUM_CH-1:0]            ch_ovf,
    input  logic                         ovf_clr,
    input  logic                         f_full,
    output logic [DATA_WIDTH-1:0]        d_out,
    output logic                         w_en,
    output logic [CW-1:0]                ch_id
);
    localparam int PW = $clog2(CH_DEPTH);
    localparam int NW = $clog2(CH_DEPTH + 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(CH_DEPTH);
    localparam logic [CW-1:0] LAST_RST = CW'(NUM_CH - 1);

    logic [DATA_WIDTH-1:0] mem [NUM_CH][CH_DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [NW-1:0]         count [NUM_CH];
    logic [CW-1:0]         last;
    logic [CW-1:0]         sel;
    logic                  any_ne;
    logic [NUM_CH-1:0]     non_empty;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     ovf_set;

    // Search starts one past the last grant, so every busy channel gets a turn.
    always_comb begin : arb
        logic [CW-1:0] cand;
        sel    = '0;
        any_ne = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CW'((int'(last) + k) % NUM_CH);
            if (!any_ne && non_empty[cand]) begin
                any_ne = 1'b1;
                sel    = cand;
            end
        end
    end

    assign w_en  = any_ne & ~f_full;
    assign d_out = w_en ? mem[sel][rd_ptr[sel]] : '0;
    assign ch_id = w_en ? sel : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign non_empty[i] = (count[i] != '0);
        assign ch_full[i]   = (count[i] == DEPTH_N);
        assign push[i]      = wr_req[i] & ~ch_full[i];
        assign ovf_set[i]   = wr_req[i] & ch_full[i];
        assign pop[i]       = w_en & (sel == CW'(i));

        always_ff @(posedge w_clk) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Full is judged on the registered count, so a pop frees space next cycle.
        always_ff @(posedge w_clk or posedge wrst) begin
            if (wrst) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                count[i] <= count[i] + NW'(push[i]) - NW'(pop[i]);
            end
        end
    end

    // A new overflow beats a simultaneous clear.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            last   <= LAST_RST;
            ch_ovf <= '0;
        end else begin
            ch_ovf <= (ovf_clr ? '0 : ch_ovf) | ovf_set;
            if (w_en) begin
                last <= sel;
            end
        end
    end

endmodule

// File: tb/tb_producer_mc.sv
// tb_producer_mc: directed self-checking bench for producer_mc.
// Writes seen by the FIFO are logged on the falling edge and checked per scenario.
module tb_producer_mc;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 2;

    logic             w_clk;
    logic             wrst;
    logic [NC-1:0]    wr_req;
    logic [NC*DW-1:0] data_in;
    logic [NC-1:0]    ch_full;
    logic [NC-1:0]    ch_ovf;
    logic             ovf_clr;
    logic             f_full;
    logic [DW-1:0]    d_out;
    logic             w_en;
    logic [CW-1:0]    ch_id;

    int tests_run;
    int tests_failed;
    logic [CW+DW-1:0] wlog [$];

    producer_mc #(
        .DATA_WIDTH(DW),
        .NUM_CH(NC),
        .CH_DEPTH(4)
    ) dut (
        .w_clk(w_clk),
        .wrst(wrst),
        .wr_req(wr_req),
        .data_in(data_in),
        .ch_full(ch_full),
        .ch_ovf(ch_ovf),
        .ovf_clr(ovf_clr),
        .f_full(f_full),
        .d_out(d_out),
        .w_en(w_en),
        .ch_id(ch_id)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    always @(negedge w_clk) begin
        if (w_en) wlog.push_back({ch_id, d_out});
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [DW-1:0] v);
        data_in[ch*DW +: DW] = v;
    endtask

    task automatic do_reset();
        wrst    = 1'b1;
        wr_req  = '0;
        f_full  = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();
        wrst = 1'b0;
        wlog.delete();
    endtask

    task automatic test_reset();
        wr_req  = '1;
        data_in = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        for (int c = 0; c < 10; c++) begin
            #2;
            tests_run++;
            if ({w_en, d_out, ch_id, ch_full, ch_ovf} !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold c=%0d: w_en=%b d_out=%h ch_full=%b ch_ovf=%b, want all 0",
                         c, w_en, d_out, ch_full, ch_ovf);
            end
            tick();
        end
        wr_req = '0;
        wrst   = 1'b0;
        tick();
        tests_run++;
        if (wlog.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_writes: got %0d writes, want 0", wlog.size());
        end
    endtask

    task automatic test_single();
        do_reset();
        tests_run++;
        if (w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: w_en=%b want 0", w_en);
        end
        for (int k = 1; k <= 3; k++) begin
            wr_req = 4'b0100;
            set_word(2, 32'hA5A5_0000 + DW'(k));
            tick();
            tests_run++;
            if ({w_en, ch_id, d_out} !== {1'b1, 2'd2, 32'hA5A5_0000 + DW'(k)}) begin
                tests_failed++;
                $display("FAIL single_word%0d: w_en=%b ch_id=%0d d_out=%h want 1/2/%h",
                         k, w_en, ch_id, d_out, 32'hA5A5_0000 + DW'(k));
            end
        end
        wr_req = '0;
        tick();
        tests_run++;
        if (w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: w_en=%b want 0", w_en);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wr_req = 4'hF;
            for (int i = 0; i < NC; i++) set_word(i, 32'h1000_0000 * (r + 1) + DW'(i));
            tick();
            wr_req = '0;
            for (int k = 0; k < NC; k++) begin
                tests_run++;
                if ({w_en, ch_id, d_out} !==
                    {1'b1, CW'(k), 32'h1000_0000 * (r + 1) + DW'(k)}) begin
                    tests_failed++;
                    $display("FAIL fair_r%0d_g%0d: w_en=%b ch_id=%0d d_out=%h want 1/%0d/%h",
                             r, k, w_en, ch_id, d_out, k, 32'h1000_0000 * (r + 1) + DW'(k));
                end
                tick();
            end
            tests_run++;
            if (w_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL fair_r%0d_idle: w_en=%b want 0", r, w_en);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        do_reset();
        sent = 0;
        for (int c = 0; c < 24; c++) begin
            f_full = (c % 2) == 1;
            if ((c % 2) == 0 && sent < 8) begin
                wr_req = 4'b0001;
                set_word(0, 32'hB000_0000 + DW'(sent));
                sent++;
            end else begin
                wr_req = '0;
            end
            #2;
            if (f_full) begin
                tests_run++;
                if (w_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_gate c=%0d: w_en=%b want 0 while f_full", c, w_en);
                end
            end
            @(posedge w_clk);
            #1;
        end
        f_full = 1'b0;
        wr_req = '0;
        repeat (4) tick();
        tests_run++;
        if (wlog.size() !== 8) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d words, want 8", wlog.size());
        end
        for (int j = 0; j < 8 && j < wlog.size(); j++) begin
            tests_run++;
            if (wlog[j] !== {2'd0, 32'hB000_0000 + DW'(j)}) begin
                tests_failed++;
                $display("FAIL bp_order%0d: got %h want %h", j, wlog[j], {2'd0, 32'hB000_0000 + DW'(j)});
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        f_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_req = 4'b0010;
            set_word(1, 32'hC000_0000 + DW'(k));
            tick();
            if (k == 2) begin
                tests_run++;
                if (ch_full !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL ovf_not_full3: ch_full=%b want 0000", ch_full);
                end
            end
            if (k == 3) begin
                tests_run++;
                if ({ch_full, ch_ovf} !== {4'b0010, 4'b0000}) begin
                    tests_failed++;
                    $display("FAIL ovf_full4: ch_full=%b ch_ovf=%b want 0010/0000", ch_full, ch_ovf);
                end
            end
            if (k == 4) begin
                tests_run++;
                if (ch_ovf !== 4'b0010) begin
                    tests_failed++;
                    $display("FAIL ovf_set: ch_ovf=%b want 0010", ch_ovf);
                end
            end
        end
        wr_req = '0;
        wlog.delete();
        f_full = 1'b0;
        repeat (8) tick();
        tests_run++;
        if (wlog.size() !== 4) begin
            tests_failed++;
            $display("FAIL ovf_count: got %0d words, want 4", wlog.size());
        end
        for (int j = 0; j < 4 && j < wlog.size(); j++) begin
            tests_run++;
            if (wlog[j] !== {2'd1, 32'hC000_0000 + DW'(j)}) begin
                tests_failed++;
                $display("FAIL ovf_order%0d: got %h want %h", j, wlog[j], {2'd1, 32'hC000_0000 + DW'(j)});
            end
        end
        tests_run++;
        if (ch_ovf !== 4'b0010) begin
            tests_failed++;
            $display("FAIL ovf_sticky: ch_ovf=%b want 0010", ch_ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (ch_ovf !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovf_clr: ch_ovf=%b want 0000", ch_ovf);
        end
        f_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_req  = 4'b1000;
            ovf_clr = (k == 4);
            set_word(3, 32'hE000_0000 + DW'(k));
            tick();
        end
        wr_req  = '0;
        ovf_clr = 1'b0;
        tests_run++;
        if (ch_ovf !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: ch_ovf=%b want 1000", ch_ovf);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        f_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_req = 4'b0100;
            set_word(2, 32'hF000_0000 + DW'(k));
            tick();
        end
        wr_req = '0;
        f_full = 1'b0;
        #2;
        tests_run++;
        if (w_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: w_en=%b want 1", w_en);
        end
        wlog.delete();
        wrst = 1'b1;
        #1;
        tests_run++;
        if ({w_en, d_out} !== '0) begin
            tests_failed++;
            $display("FAIL mid_async: w_en=%b d_out=%h want 0/0", w_en, d_out);
        end
        tick();
        wrst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (w_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_stale c=%0d: w_en=%b want 0", c, w_en);
            end
        end
        tests_run++;
        if (wlog.size() !== 0) begin
            tests_failed++;
            $display("FAIL mid_log: got %0d writes, want 0", wlog.size());
        end
        wr_req = 4'b1001;
        set_word(0, 32'hD000_0000);
        set_word(3, 32'hD000_0003);
        tick();
        wr_req = '0;
        tests_run++;
        if ({w_en, ch_id, d_out} !== {1'b1, 2'd0, 32'hD000_0000}) begin
            tests_failed++;
            $display("FAIL mid_grant0: w_en=%b ch_id=%0d d_out=%h want 1/0/d0000000", w_en, ch_id, d_out);
        end
        tick();
        tests_run++;
        if ({w_en, ch_id, d_out} !== {1'b1, 2'd3, 32'hD000_0003}) begin
            tests_failed++;
            $display("FAIL mid_grant3: w_en=%b ch_id=%0d d_out=%h want 1/3/d0000003", w_en, ch_id, d_out);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wrst    = 1'b1;
        wr_req  = '0;
        data_in = '0;
        ovf_clr = 1'b0;
        f_full  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
